// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N-LED pattern generator with prescaled stepping.
// Patterns: fill/clear from LSB, fill/clear from MSB, ping-pong dot, blink.
// A change on 'mode' reloads the new pattern's start point on the next edge.
// 'done' is a registered one-cycle pulse for each completed pattern period.
// 'state_dbg' exposes the FSM state for observation.
module led_pattern_gen #(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rs,
  input  logic         en,
  input  logic [1:0]   mode,
  output logic [N-1:0] led,
  output logic         done,
  output logic [2:0]   state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_TURN = CW'(N - 2);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_CLEAR = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_ON    = 3'd4,
    S_OFF   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [PW-1:0]  pre_q,   pre_d;
  logic [1:0]     mode_q,  mode_d;
  logic [N-1:0]   led_q,   led_d;
  logic           done_q,  done_d;

  logic           tick;
  logic           mode_change;

  assign tick        = en && (pre_q == PRE_MAX);
  assign mode_change = (mode != mode_q);

  // Prescaler: counts enabled cycles 0..DIV-1; a mode change restarts it.
  always_comb begin
    pre_d = pre_q;
    if (mode_change) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PRE_MAX) pre_d = '0;
      else                  pre_d = pre_q + PW'(1);
    end
  end

  // Pattern FSM: a mode change loads the start point (and drops any tick on
  // the same edge); otherwise each tick advances the pattern one step.
  // mode_q[0] selects the shift direction for the fill/clear states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (mode_change) begin
      mode_d = mode;
      cnt_d  = '0;
      case (mode)
        2'b10: begin
          state_d = S_UP;
          led_d   = N'(1);
        end
        2'b11: begin
          state_d = S_OFF;
          led_d   = '0;
        end
        default: begin
          state_d = S_FILL;
          led_d   = '0;
        end
      endcase
    end else if (tick) begin
      case (state_q)
        S_FILL: begin
          led_d = mode_q[0] ? {1'b1, led_q[N-1:1]} : {led_q[N-2:0], 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CLEAR: begin
          led_d = mode_q[0] ? {1'b0, led_q[N-1:1]} : {led_q[N-2:0], 1'b0};
          if (cnt_q == CNT_LAST) begin
            state_d = S_FILL;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_UP: begin
          led_d = led_q << 1;
          if (cnt_q == CNT_TURN) begin
            state_d = S_DOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DOWN: begin
          led_d = led_q >> 1;
          if (cnt_q == CNT_TURN) begin
            state_d = S_UP;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_OFF: begin
          led_d   = '1;
          state_d = S_ON;
        end
        S_ON: begin
          led_d   = '0;
          state_d = S_OFF;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_FILL;
          cnt_d   = '0;
          led_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      pre_q   <= '0;
      mode_q  <= 2'b00;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led       = led_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: one DIV=1 instance for the pattern sequences,
// reset and mode-change behaviour, one DIV=4 instance for blink with an
// enable hold. Expected {done,led} words are queued before each edge and
// popped and compared after it.
module tb_led_pattern_gen;

  localparam int N = 8;
  localparam int W = N + 1;

  // Clock / reset / DUT signals
  logic         clk = 1'b0;
  logic         rs1, en1, rs4, en4;
  logic [1:0]   mode1, mode4;
  logic [N-1:0] led1, led4;
  logic         done1, done4;
  logic [2:0]   state1, state4;

  always #5 clk = ~clk;

  led_pattern_gen #(.N(N), .DIV(1)) dut1 (
    .clk(clk), .rs(rs1), .en(en1), .mode(mode1),
    .led(led1), .done(done1), .state_dbg(state1)
  );

  led_pattern_gen #(.N(N), .DIV(4)) dut4 (
    .clk(clk), .rs(rs4), .en(en4), .mode(mode4),
    .led(led4), .done(done4), .state_dbg(state4)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp4_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic d, input logic [N-1:0] l);
    exp_q.push_back({d, l});
  endtask

  task automatic push4(input logic d, input logic [N-1:0] l);
    exp4_q.push_back({d, l});
  endtask

  // One clock: sample #1 after the rising edge, compare, return at negedge.
  task automatic edge_chk(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0)  chk({tag, "/div1"}, {done1, led1}, exp_q.pop_front());
    if (exp4_q.size() > 0) chk({tag, "/div4"}, {done4, led4}, exp4_q.pop_front());
    @(negedge clk);
  endtask

  logic [N-1:0] seq00 [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                               8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [N-1:0] seq01 [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                               8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
  logic [N-1:0] seq10 [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int k;
    rs1 = 1'b1; rs4 = 1'b1; en1 = 1'b0; en4 = 1'b0;
    mode1 = 2'b00; mode4 = 2'b00;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("reset_out", {done1, led1}, '0);
    chk("reset_state", W'(state1), W'(0));
    chk("reset_out4", {done4, led4}, '0);
    rs1 = 1'b0; rs4 = 1'b0; en1 = 1'b1;

    // Mode 00, with a 3-cycle enable hold at all-ones
    for (int i = 0; i < 8; i++) push1(1'b0, seq00[i]);
    repeat (8) edge_chk("m00_fill");
    en1 = 1'b0;
    repeat (3) push1(1'b0, 8'hFF);
    repeat (3) edge_chk("m00_hold");
    en1 = 1'b1;
    for (int i = 8; i < 16; i++) push1(i == 15, seq00[i]);
    repeat (8) edge_chk("m00_clear");

    // Mode 01: load edge (tick discarded), then 16 ticks
    mode1 = 2'b01;
    push1(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) push1(i == 15, seq01[i]);
    repeat (17) edge_chk("m01");
    en1 = 1'b0;
    push1(1'b0, 8'h00);
    edge_chk("m01_en_low");
    en1 = 1'b1;

    // Mode 10: load 01, then ping-pong with no repeat at the ends
    mode1 = 2'b10;
    push1(1'b0, 8'h01);
    for (int i = 0; i < 15; i++) push1(i == 13, seq10[i]);
    repeat (16) edge_chk("m10");

    // Mode 00 to 0x3F, switch to mode 10, then async reset mid-pattern
    mode1 = 2'b00;
    push1(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) push1(1'b0, seq00[i]);
    repeat (7) edge_chk("m00_to_3f");
    mode1 = 2'b10;
    push1(1'b0, 8'h01);
    edge_chk("switch_to_m10");
    push1(1'b0, 8'h02);
    edge_chk("m10_after_switch");
    #2 rs1 = 1'b1;
    #1 chk("async_reset", {done1, led1}, '0);
    chk("async_reset_state", W'(state1), W'(0));
    push1(1'b0, 8'h00);
    edge_chk("reset_held");
    rs1 = 1'b0;
    push1(1'b0, 8'h01);
    edge_chk("post_reset_load");

    // DIV=4 blink with a 7-cycle enable hold
    mode4 = 2'b11; en4 = 1'b1; en1 = 1'b0;
    push4(1'b0, 8'h00);
    edge_chk("m11_load");
    k = 0;
    for (int i = 0; i < 24; i++) begin
      if (k == 6) begin
        en4 = 1'b0;
        repeat (7) begin
          push4(1'b0, 8'hFF);
          edge_chk("m11_hold");
        end
        en4 = 1'b1;
      end
      k++;
      push4((k % 8) == 0, ((k / 4) % 2) == 1 ? 8'hFF : 8'h00);
      edge_chk("m11_blink");
    end

    chk("queues_drained", W'(exp_q.size() + exp4_q.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter N, default 8: LED count, legal range 2..32.
REQ-002 Parameter DIV, default 1: clock cycles per pattern step, legal range 1..2^16.
REQ-003 clk  input  1  Single system clock; all state updates on the rising edge.
REQ-004 rs  input  1  Reset, asynchronous and active-high.
REQ-005 en  input  1  Step enable; while low, all state holds.
REQ-006 mode  input  2  Pattern select: 00 fill/clear from LSB, 01 fill/clear from MSB, 10 ping-pong dot, 11 blink.
REQ-007 led  output  N  Registered LED drive; bit i drives LED i.
REQ-008 done  output  1  Registered one-cycle pulse marking completion of one full pattern period.

Function
REQ-009 Prescaler: a counter runs 0..DIV-1 while en=1 and wraps after DIV-1; tick = (en=1 and count=DIV-1); with DIV=1, tick is every enabled cycle.
REQ-010 While en=0, the prescaler, led, FSM state and step counter hold their values, and done is 0.
REQ-011 The FSM SHALL have the states FILL, CLEAR, UP, DOWN, ON and OFF, plus a step counter of width clog2(N+1).
REQ-012 Mode 00: FILL state, each tick led <= {led[N-2:0],1}; after N ticks led is all ones and the FSM enters CLEAR.
REQ-013 Mode 00 CLEAR state: each tick led <= {led[N-2:0],0}; after N ticks led is all zeros and the FSM returns to FILL; period 2N ticks.
REQ-014 Mode 01: same as mode 00 but mirrored: FILL shifts 1 in at the MSB ({1,led[N-1:1]}), CLEAR shifts 0 in at the MSB; period 2N ticks.
REQ-015 Mode 10: exactly one bit set; start at bit 0; UP state shifts left each tick until bit N-1, then DOWN shifts right until bit 0; period 2N-2 ticks; no bit is repeated at either turn-around.
REQ-016 Mode 11: each tick led toggles between all zeros (OFF) and all ones (ON); start OFF; period 2 ticks.
REQ-017 Initial value per mode: 00, 01 and 11 = all zeros; 10 = 1 at bit 0.
REQ-018 mode is registered internally as mode_q. When mode differs from mode_q, on the next clock edge, regardless of en or tick:
- mode_q <= mode;
- led <= initial value of the new mode;
- FSM and step counter go to the new mode's start state;
- prescaler clears to 0;
- done = 0.
REQ-019 done = 1 for exactly the one cycle in which led is updated back to its initial value by a tick that completes a period; a mode-change load (REQ-018) never asserts done.
REQ-020 If a mode change and a tick occur on the same edge, the mode change wins and the tick is discarded.
REQ-021 All arithmetic is unsigned. The prescaler and step counter wrap only as specified and never overflow their widths.

Reset
REQ-022 While rs=1, asynchronously and regardless of clk:
- led = 0, done = 0;
- prescaler = 0, step counter = 0;
- FSM = FILL, mode_q = 00.
REQ-023 After rs deasserts with mode≠00, the first edge performs the REQ-018 load. With mode=00, stepping starts from the all-zero pattern.
REQ-024 Asserting rs mid-pattern SHALL abort the pattern immediately, with no completion done pulse.

Verification (N=8, unless noted DIV=1)
REQ-025 Reset check: rs=1 for 2 cycles, then mode=00, en=1 -> during reset led=0x00 and done=0. Ticks 1..16 give led = 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00. done=1 only on tick 16.
REQ-026 Mode 01, en=1 -> led = 80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00, with done on the 16th tick.
REQ-027 Mode 10 -> first edge loads 01. Ticks then give 02,04,...,80,40,...,01. done on tick 14, and no value is repeated at 80 or 01.
REQ-028 DIV=4, mode 11, en=1 -> led toggles 00/FF every 4 clk. Driving en=0 for 7 cycles mid-run holds led and the prescaler; done pulses every 8 cycles of enabled time.
REQ-029 Mode 00 running at led=0x3F: switch mode to 10 -> next edge led=0x01 with done=0. Then assert rs asynchronously between edges -> led=0x00 immediately, with no done pulse.
